imm_decode_stage: RTL and testbench

Registered instruction-decode front stage: classifies a 32-bit RISC-V instruction by opcode, produces the sign-extended immediate at XLEN width (32 or 64), and forwards instruction, PC, type, immediate and an illegal flag to the execute side through a valid/ready handshake. Sits between fetch and register-read. An optional 2-entry skid buffer gives full throughput with a registered `in_ready`.

---
 rtl/imm_decode_stage_pkg.sv | 33 +++
 rtl/imm_decode_stage_if.sv | 29 ++
 rtl/imm_decode_stage_imm_extract.sv | 56 +++++
 rtl/imm_decode_stage.sv | 105 ++++++++++
 tb/tb_imm_decode_stage.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_decode_stage_pkg.sv
// Shared decode types: instruction class, RV opcode values and the skid FSM state.
package typedefs;

  typedef enum logic [2:0] {
    INST_TYPE_R = 3'd0,
    INST_TYPE_I = 3'd1,
    INST_TYPE_S = 3'd2,
    INST_TYPE_B = 3'd3,
    INST_TYPE_U = 3'd4,
    INST_TYPE_J = 3'd5
  } InstructionType;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage; master = environment, slave = stage.
interface imm_decode_stage_if
  import typedefs::*;
#(
  parameter int XLEN = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [XLEN-1:0]  out_pc;
  InstructionType   out_type;
  logic [XLEN-1:0]  out_imm;
  logic             out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_type, out_imm, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_type, out_imm, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage_imm_extract.sv
// Combinational opcode classifier and sign-extended immediate builder; zero latency, no flow control.
module imm_extract
  import typedefs::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output InstructionType  inst_type,
  output logic            illegal
);

  // Every format is first built as a signed 32-bit value, then widened by a sign-extending cast.
  logic signed [31:0] v;

  always_comb begin
    v         = '0;
    inst_type = INST_TYPE_R;
    illegal   = 1'b0;
    case (inst[6:0])
      OPC_OP: inst_type = INST_TYPE_R;
      OPC_OP_32: illegal = (XLEN != 64);
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
        inst_type = INST_TYPE_I;
        v         = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          inst_type = INST_TYPE_I;
          v         = {{20{inst[31]}}, inst[31:20]};
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        inst_type = INST_TYPE_S;
        v         = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        inst_type = INST_TYPE_B;
        v         = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        inst_type = INST_TYPE_U;
        v         = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        inst_type = INST_TYPE_J;
        v         = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
    imm = XLEN'(v);
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode stage: 1-cycle latency; optional 2-entry skid keeps full rate with a registered in_ready,
// otherwise in_ready = !out_valid || out_ready. Outputs hold stable while stalled; flush empties the stage.
module imm_decode_stage
  import typedefs::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_decode_stage_if.slave  bus
);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    InstructionType  itype;
    logic            illegal;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  InstructionType  dec_type;
  logic            dec_illegal;
  entry_t          dec_e;

  imm_extract #(.XLEN(XLEN)) u_imm_extract (
    .inst      (bus.in_inst),
    .imm       (dec_imm),
    .inst_type (dec_type),
    .illegal   (dec_illegal)
  );

  assign dec_e = '{inst: bus.in_inst, pc: bus.in_pc, imm: dec_imm,
                   itype: dec_type, illegal: dec_illegal};

  skid_state_t state;
  entry_t      main_q;
  entry_t      skid_q;
  logic        main_vld;
  logic        rdy_q;
  logic        in_xfer;
  logic        out_xfer;

  // Without the skid, ONE + input + no output cannot occur because in_ready is low then, so FULL is unreachable.
  assign bus.in_ready = SKID ? rdy_q : (!main_vld || bus.out_ready);
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign out_xfer     = main_vld && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SKID_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (bus.flush) begin
      state    <= SKID_EMPTY;
      main_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (in_xfer) begin
            main_q   <= dec_e;
            main_vld <= 1'b1;
            state    <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= dec_e;
          end else if (in_xfer) begin
            skid_q <= dec_e;
            rdy_q  <= 1'b0;
            state  <= SKID_FULL;
          end else if (out_xfer) begin
            main_vld <= 1'b0;
            state    <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_xfer) begin
            main_q <= skid_q;
            rdy_q  <= 1'b1;
            state  <= SKID_ONE;
          end
        end
        default: begin
          main_vld <= 1'b0;
          rdy_q    <= 1'b1;
          state    <= SKID_EMPTY;
        end
      endcase
    end
  end

  assign bus.out_valid   = main_vld;
  assign bus.out_inst    = main_q.inst;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_type    = main_q.itype;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboarded bench: XLEN=32/SKID=1 and XLEN=64/SKID=0 instances under directed and random traffic.
module tb_imm_decode_stage;
  import typedefs::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) ia ();
  imm_decode_stage_if #(.XLEN(64)) ib ();

  imm_decode_stage #(.XLEN(32), .SKID(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  imm_decode_stage #(.XLEN(64), .SKID(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  typedef struct {
    logic [31:0]    inst;
    logic [63:0]    pc;
    logic [63:0]    imm;
    InstructionType t;
    logic           ill;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic miss(input string name);
    total++;
    $display("FAIL %s: output with no expected entry", name);
  endtask

  function automatic longint sx(input longint v, input int bits);
    return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
  endfunction

  // Reference: fields picked out arithmetically, sign applied by two's-complement range folding.
  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc, input int xlen);
    exp_t   e;
    longint u;
    longint imm;
    int     op;
    u     = longint'(inst);
    op    = int'(u & 127);
    imm   = 0;
    e.t   = INST_TYPE_R;
    e.ill = 1'b0;
    case (op)
      'h33: e.t = INST_TYPE_R;
      'h3B: if (xlen != 64) e.ill = 1'b1;
      'h13, 'h03, 'h67, 'h73, 'h0F: begin e.t = INST_TYPE_I; imm = sx(u >> 20, 12); end
      'h1B: begin
        if (xlen == 64) begin e.t = INST_TYPE_I; imm = sx(u >> 20, 12); end
        else e.ill = 1'b1;
      end
      'h23: begin e.t = INST_TYPE_S; imm = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12); end
      'h63: begin
        e.t = INST_TYPE_B;
        imm = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                 (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      end
      'h37, 'h17: begin e.t = INST_TYPE_U; imm = sx(u & 64'hFFFFF000, 32); end
      'h6F: begin
        e.t = INST_TYPE_J;
        imm = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                 (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      end
      default: e.ill = 1'b1;
    endcase
    e.inst = inst;
    e.pc   = (xlen == 32) ? (pc & 64'hFFFFFFFF) : pc;
    e.imm  = (xlen == 32) ? (imm & 64'hFFFFFFFF) : imm;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [15] = '{7'h33, 7'h3B, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h1B,
                              7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h32};
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 14)]};
  endfunction

  // Monitors: pop/compare on output transfer, push model result on input transfer, check stall stability.
  exp_t ea, sa;
  logic hold_a = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      hold_a = 1'b0;
    end else begin
      if (hold_a) begin
        chk("a_hold_inst", 64'(ia.out_inst), sa.inst);
        chk("a_hold_pc", 64'(ia.out_pc), sa.pc);
        chk("a_hold_imm", 64'(ia.out_imm), sa.imm);
        chk("a_hold_type", 64'(ia.out_type), 64'(sa.t));
        chk("a_hold_ill", 64'(ia.out_illegal), 64'(sa.ill));
      end
      if (ia.out_valid && ia.out_ready) begin
        if (qa.size() == 0) miss("a_unexpected_output");
        else begin
          ea = qa.pop_front();
          chk("a_inst", 64'(ia.out_inst), ea.inst);
          chk("a_pc", 64'(ia.out_pc), ea.pc);
          chk("a_type", 64'(ia.out_type), 64'(ea.t));
          chk("a_imm", 64'(ia.out_imm), ea.imm);
          chk("a_illegal", 64'(ia.out_illegal), 64'(ea.ill));
        end
      end
      hold_a  = ia.out_valid && !ia.out_ready && !ia.flush;
      sa.inst = ia.out_inst;
      sa.pc   = 64'(ia.out_pc);
      sa.imm  = 64'(ia.out_imm);
      sa.t    = ia.out_type;
      sa.ill  = ia.out_illegal;
      if (ia.flush) qa.delete();
      else if (ia.in_valid && ia.in_ready) qa.push_back(model(ia.in_inst, 64'(ia.in_pc), 32));
    end
  end

  exp_t eb, sb;
  logic hold_b = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
      hold_b = 1'b0;
    end else begin
      if (hold_b) begin
        chk("b_hold_inst", 64'(ib.out_inst), sb.inst);
        chk("b_hold_pc", ib.out_pc, sb.pc);
        chk("b_hold_imm", ib.out_imm, sb.imm);
        chk("b_hold_type", 64'(ib.out_type), 64'(sb.t));
        chk("b_hold_ill", 64'(ib.out_illegal), 64'(sb.ill));
      end
      if (ib.out_valid && ib.out_ready) begin
        if (qb.size() == 0) miss("b_unexpected_output");
        else begin
          eb = qb.pop_front();
          chk("b_inst", 64'(ib.out_inst), eb.inst);
          chk("b_pc", ib.out_pc, eb.pc);
          chk("b_type", 64'(ib.out_type), 64'(eb.t));
          chk("b_imm", ib.out_imm, eb.imm);
          chk("b_illegal", 64'(ib.out_illegal), 64'(eb.ill));
        end
      end
      hold_b  = ib.out_valid && !ib.out_ready && !ib.flush;
      sb.inst = ib.out_inst;
      sb.pc   = ib.out_pc;
      sb.imm  = ib.out_imm;
      sb.t    = ib.out_type;
      sb.ill  = ib.out_illegal;
      if (ib.flush) qb.delete();
      else if (ib.in_valid && ib.in_ready) qb.push_back(model(ib.in_inst, ib.in_pc, 64));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ia.flush = 0; ia.in_valid = 0; ia.in_inst = '0; ia.in_pc = '0; ia.out_ready = 0;
    ib.flush = 0; ib.in_valid = 0; ib.in_inst = '0; ib.in_pc = '0; ib.out_ready = 0;

    #12;
    chk("rst_a_out_valid", 64'(ia.out_valid), 64'd0);
    chk("rst_a_in_ready", 64'(ia.in_ready), 64'd1);
    chk("rst_a_out_inst", 64'(ia.out_inst), 64'd0);
    chk("rst_a_out_pc", 64'(ia.out_pc), 64'd0);
    chk("rst_a_out_imm", 64'(ia.out_imm), 64'd0);
    chk("rst_a_out_type", 64'(ia.out_type), 64'(INST_TYPE_R));
    chk("rst_a_out_illegal", 64'(ia.out_illegal), 64'd0);
    chk("rst_b_out_valid", 64'(ib.out_valid), 64'd0);
    chk("rst_b_in_ready", 64'(ib.in_ready), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // BEQ on A, LUI on B.
    step();
    ia.in_valid = 1; ia.in_inst = 32'hFE000EE3; ia.in_pc = 32'h0000_0100; ia.out_ready = 1;
    ib.in_valid = 1; ib.in_inst = 32'h800002B7; ib.in_pc = 64'h0000_0000_0000_2000; ib.out_ready = 1;
    step();
    ia.in_inst = 32'h0000001B;
    ib.in_inst = 32'h0080006F;
    @(negedge clk);
    chk("beq_valid", 64'(ia.out_valid), 64'd1);
    chk("beq_type", 64'(ia.out_type), 64'(INST_TYPE_B));
    chk("beq_imm", 64'(ia.out_imm), 64'h0000_0000_FFFF_FFFC);
    chk("beq_illegal", 64'(ia.out_illegal), 64'd0);
    chk("lui64_imm", ib.out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui64_type", 64'(ib.out_type), 64'(INST_TYPE_U));
    step();
    ia.in_valid = 0;
    ib.in_inst = 32'h0000001B;
    @(negedge clk);
    chk("opimm32_x32_illegal", 64'(ia.out_illegal), 64'd1);
    chk("opimm32_x32_imm", 64'(ia.out_imm), 64'd0);
    chk("opimm32_x32_type", 64'(ia.out_type), 64'(INST_TYPE_R));
    chk("jal64_imm", ib.out_imm, 64'd8);
    chk("jal64_type", 64'(ib.out_type), 64'(INST_TYPE_J));
    step();
    ib.in_valid = 0;
    @(negedge clk);
    chk("opimm32_x64_type", 64'(ib.out_type), 64'(INST_TYPE_I));
    chk("opimm32_x64_illegal", 64'(ib.out_illegal), 64'd0);

    // Four back-to-back pushes into A with the output stalled.
    step();
    ia.in_valid = 1; ia.in_inst = rand_inst(); ia.in_pc = $urandom(); ia.out_ready = 0;
    @(negedge clk); chk("bp_c1_in_ready", 64'(ia.in_ready), 64'd1);
    step(); ia.in_inst = rand_inst(); ia.in_pc = $urandom();
    @(negedge clk); chk("bp_c2_in_ready", 64'(ia.in_ready), 64'd1);
    step(); ia.in_inst = rand_inst(); ia.in_pc = $urandom();
    @(negedge clk); chk("bp_c3_in_ready", 64'(ia.in_ready), 64'd0);
    step();
    @(negedge clk); chk("bp_c4_in_ready", 64'(ia.in_ready), 64'd0);
    step(); ia.out_ready = 1;
    @(negedge clk); chk("bp_drain_in_ready", 64'(ia.in_ready), 64'd0);
    step();
    @(negedge clk); chk("bp_after_drain_in_ready", 64'(ia.in_ready), 64'd1);
    step(); ia.in_inst = rand_inst(); ia.in_pc = $urandom();
    step(); ia.in_valid = 0;
    repeat (3) step();
    @(negedge clk); chk("bp_all_drained", 64'(qa.size()), 64'd0);

    // Flush while FULL with a same-cycle input.
    step(); ia.out_ready = 0; ia.in_valid = 1; ia.in_inst = rand_inst(); ia.in_pc = $urandom();
    step(); ia.in_inst = rand_inst(); ia.in_pc = $urandom();
    step(); ia.in_inst = 32'h12345013; ia.flush = 1;
    step(); ia.flush = 0; ia.in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", 64'(ia.out_valid), 64'd0);
    chk("flush_in_ready", 64'(ia.in_ready), 64'd1);
    step(); ia.out_ready = 1;
    repeat (2) step();

    // Asynchronous reset while FULL.
    step(); ia.out_ready = 0; ia.in_valid = 1; ia.in_inst = rand_inst(); ia.in_pc = $urandom();
    step(); ia.in_inst = rand_inst(); ia.in_pc = $urandom();
    step(); ia.in_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_a_out_valid", 64'(ia.out_valid), 64'd0);
    chk("arst_a_in_ready", 64'(ia.in_ready), 64'd1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(); ia.in_valid = 1; ia.in_inst = 32'h00A00093; ia.in_pc = 32'h0000_0040; ia.out_ready = 1;
    step(); ia.in_valid = 0;
    @(negedge clk);
    chk("arst_latency_valid", 64'(ia.out_valid), 64'd1);
    chk("arst_latency_inst", 64'(ia.out_inst), 64'h0000_0000_00A0_0093);

    // Random traffic on both instances.
    for (int n = 0; n < 1500; n++) begin
      step();
      ia.in_valid = ($urandom_range(0, 3) != 0);
      ia.in_inst = rand_inst(); ia.in_pc = $urandom();
      ia.out_ready = ($urandom_range(0, 2) != 0);
      ia.flush = 0;
      if ($urandom_range(0, 40) == 0) begin ia.flush = 1; ia.out_ready = 0; end
      ib.in_valid = ($urandom_range(0, 3) != 0);
      ib.in_inst = rand_inst(); ib.in_pc = {$urandom(), $urandom()};
      ib.out_ready = ($urandom_range(0, 2) != 0);
      ib.flush = 0;
      if ($urandom_range(0, 40) == 0) begin ib.flush = 1; ib.out_ready = 0; end
    end
    step();
    ia.in_valid = 0; ia.flush = 0; ia.out_ready = 1;
    ib.in_valid = 0; ib.flush = 0; ib.out_ready = 1;
    repeat (5) step();
    @(negedge clk);
    chk("final_a_drained", 64'(qa.size()), 64'd0);
    chk("final_b_drained", 64'(qb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
